// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit limit, collector state encoding and digit sanitizer.
package bcd_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  // Returns {bad, stored_digit}; non-decimal codes are stored as zero.
  function automatic logic [4:0] bcd_sanitize(input logic [3:0] digit);
    return (digit > BCD_MAX) ? {1'b1, 4'd0} : {1'b0, digit};
  endfunction

endpackage

// File: rtl/bcd_frame_collector_if.sv
// Digit-in / frame-out handshake bundle for bcd_frame_collector.
interface bcd_frame_collector_if #(
  parameter int unsigned NUM_DIGITS = 300
);
  localparam int unsigned CNT_W = $clog2(NUM_DIGITS + 1);

  logic                    in_valid;
  logic                    in_ready;
  logic [3:0]              bcd_digit;
  logic                    in_last;
  logic [4*NUM_DIGITS-1:0] dec;
  logic                    out_valid;
  logic                    out_ready;
  logic [CNT_W-1:0]        digit_count;
  logic [CNT_W-1:0]        bad_count;
  logic                    err;

  modport master (
    output in_valid, bcd_digit, in_last, out_ready,
    input  in_ready, dec, out_valid, digit_count, bad_count, err
  );

  modport slave (
    input  in_valid, bcd_digit, in_last, out_ready,
    output in_ready, dec, out_valid, digit_count, bad_count, err
  );

endinterface

// File: rtl/bcd_digit_check.sv
// Combinational BCD digit sanitizer: flags codes above 9 and substitutes zero.
module bcd_digit_check
  import bcd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] stored_digit,
  output logic       bad
);

  assign {bad, stored_digit} = bcd_sanitize(digit);

endmodule

// File: rtl/bcd_frame_collector.sv
// Collects BCD digits into a frame of up to NUM_DIGITS, then holds it until consumed.
module bcd_frame_collector
  import bcd_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 300,
  parameter bit          MSD_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  bcd_frame_collector_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(NUM_DIGITS + 1);

  state_t                  state;
  logic [4*NUM_DIGITS-1:0] dec_q;
  logic [4*NUM_DIGITS-1:0] dec_nxt;
  logic [CNT_W-1:0]        digit_count_q;
  logic [CNT_W-1:0]        bad_count_q;
  logic [3:0]              stored;
  logic                    bad;
  logic                    accept;
  logic                    frame_end;

  bcd_digit_check u_check (
    .digit        (bus.bcd_digit),
    .stored_digit (stored),
    .bad          (bad)
  );

  assign accept    = bus.in_valid && (state == COLLECT);
  assign frame_end = bus.in_last || (digit_count_q == CNT_W'(NUM_DIGITS - 1));

  generate
    if (MSD_FIRST) begin : g_msd_first
      assign dec_nxt = {dec_q[4*NUM_DIGITS-5:0], stored};
    end else begin : g_lsd_first
      // Decoded slot write keeps every index constant and in range.
      always_comb begin
        dec_nxt = dec_q;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
          if (digit_count_q == CNT_W'(k)) dec_nxt[4*k +: 4] = stored;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= COLLECT;
      dec_q         <= '0;
      digit_count_q <= '0;
      bad_count_q   <= '0;
    end else if (clear) begin
      state         <= COLLECT;
      dec_q         <= '0;
      digit_count_q <= '0;
      bad_count_q   <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (accept) begin
            dec_q         <= dec_nxt;
            digit_count_q <= digit_count_q + 1'b1;
            bad_count_q   <= bad_count_q + CNT_W'(bad);
            if (frame_end) state <= HOLD;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state         <= COLLECT;
            dec_q         <= '0;
            digit_count_q <= '0;
            bad_count_q   <= '0;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  assign bus.in_ready    = (state == COLLECT);
  assign bus.out_valid   = (state == HOLD);
  assign bus.dec         = dec_q;
  assign bus.digit_count = digit_count_q;
  assign bus.bad_count   = bad_count_q;
  assign bus.err         = |bad_count_q;

endmodule

// File: tb/tb_bcd_frame_collector.sv
// Scoreboard bench: MSD-first and LSD-first collectors (4 digits) with directed frames.
module tb_bcd_frame_collector;

  typedef struct {
    logic [15:0] dec;
    int          cnt;
    int          bad;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clear = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  exp_t q_m[$];
  exp_t q_l[$];

  bcd_frame_collector_if #(.NUM_DIGITS(4)) bm ();
  bcd_frame_collector_if #(.NUM_DIGITS(4)) bl ();

  bcd_frame_collector #(.NUM_DIGITS(4), .MSD_FIRST(1'b1)) dut_m (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .bus   (bm.slave)
  );

  bcd_frame_collector #(.NUM_DIGITS(4), .MSD_FIRST(1'b0)) dut_l (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .bus   (bl.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_frame(input string tag, input exp_t e, input logic [15:0] dec,
                             input logic [2:0] cnt, input logic [2:0] bad, input logic err);
    chk({tag, "_dec"}, 32'(dec), 32'(e.dec));
    chk({tag, "_count"}, 32'(cnt), 32'(e.cnt));
    chk({tag, "_bad"}, 32'(bad), 32'(e.bad));
    chk({tag, "_err"}, 32'(err), 32'(e.bad != 0));
  endtask

  // Drives one digit and waits for acceptance; returns the number of stalled cycles.
  task automatic send(input bit lsd, input logic [3:0] d, input logic last, output int stalls);
    logic ok;
    stalls = 0;
    if (lsd) begin bl.in_valid = 1'b1; bl.bcd_digit = d; bl.in_last = last; end
    else     begin bm.in_valid = 1'b1; bm.bcd_digit = d; bm.in_last = last; end
    forever begin
      @(negedge clk);
      ok = lsd ? bl.in_ready : bm.in_ready;
      @(posedge clk); #1;
      if (ok) break;
      stalls++;
      if (stalls > 50) begin
        chk("accept_timeout", 32'(stalls), 32'd0);
        break;
      end
    end
    if (lsd) begin bl.in_valid = 1'b0; bl.in_last = 1'b0; end
    else     begin bm.in_valid = 1'b0; bm.in_last = 1'b0; end
  endtask

  task automatic pulse_out_ready(input bit lsd);
    @(negedge clk);
    if (lsd) bl.out_ready = 1'b1; else bm.out_ready = 1'b1;
    @(posedge clk); #1;
    if (lsd) bl.out_ready = 1'b0; else bm.out_ready = 1'b0;
  endtask

  initial begin
    int st;
    bm.in_valid = 1'b0; bm.bcd_digit = '0; bm.in_last = 1'b0; bm.out_ready = 1'b0;
    bl.in_valid = 1'b0; bl.bcd_digit = '0; bl.in_last = 1'b0; bl.out_ready = 1'b0;

    fork
      begin : mon_m
        logic pv = 1'b0;
        exp_t e;
        forever begin
          @(negedge clk);
          if (bm.out_valid && !pv) begin
            if (q_m.size() == 0) chk("msd_unexpected_frame", 32'(bm.dec), 32'hFFFF_FFFF);
            else begin
              e = q_m.pop_front();
              check_frame("msd", e, bm.dec, bm.digit_count, bm.bad_count, bm.err);
            end
          end
          pv = bm.out_valid;
        end
      end
      begin : mon_l
        logic pv = 1'b0;
        exp_t e;
        forever begin
          @(negedge clk);
          if (bl.out_valid && !pv) begin
            if (q_l.size() == 0) chk("lsd_unexpected_frame", 32'(bl.dec), 32'hFFFF_FFFF);
            else begin
              e = q_l.pop_front();
              check_frame("lsd", e, bl.dec, bl.digit_count, bl.bad_count, bl.err);
            end
          end
          pv = bl.out_valid;
        end
      end
    join_none

    // Reset values
    #3;
    chk("rst_dec", 32'(bm.dec), 32'd0);
    chk("rst_count", 32'(bm.digit_count), 32'd0);
    chk("rst_bad", 32'(bm.bad_count), 32'd0);
    chk("rst_err", 32'(bm.err), 32'd0);
    chk("rst_out_valid", 32'(bm.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bm.in_ready), 32'd1);
    #10 reset = 1'b0;
    @(posedge clk); #1;

    // Full frame ends without in_last, MSD first
    q_m.push_back('{16'h1234, 4, 0});
    send(1'b0, 4'd1, 1'b0, st);
    send(1'b0, 4'd2, 1'b0, st);
    send(1'b0, 4'd3, 1'b0, st);
    send(1'b0, 4'd4, 1'b0, st);
    chk("full_out_valid", 32'(bm.out_valid), 32'd1);
    chk("full_in_ready", 32'(bm.in_ready), 32'd0);
    pulse_out_ready(1'b0);
    chk("rel_in_ready", 32'(bm.in_ready), 32'd1);
    chk("rel_dec", 32'(bm.dec), 32'd0);
    chk("rel_count", 32'(bm.digit_count), 32'd0);

    // Short frame, LSD first, then held against incoming digits
    q_l.push_back('{16'h0021, 2, 0});
    send(1'b1, 4'd1, 1'b0, st);
    send(1'b1, 4'd2, 1'b1, st);
    bl.in_valid = 1'b1; bl.bcd_digit = 4'd9;
    repeat (5) @(posedge clk);
    #1;
    bl.in_valid = 1'b0;
    chk("hold_dec", 32'(bl.dec), 32'h0021);
    chk("hold_count", 32'(bl.digit_count), 32'd2);
    chk("hold_out_valid", 32'(bl.out_valid), 32'd1);
    pulse_out_ready(1'b1);

    // Invalid digits substituted with zero
    q_m.push_back('{16'h7003, 4, 2});
    send(1'b0, 4'd7, 1'b0, st);
    send(1'b0, 4'hC, 1'b0, st);
    send(1'b0, 4'hF, 1'b0, st);
    send(1'b0, 4'd3, 1'b1, st);
    chk("bad_err_held", 32'(bm.err), 32'd1);
    pulse_out_ready(1'b0);
    chk("bad_clr_bad", 32'(bm.bad_count), 32'd0);
    chk("bad_clr_err", 32'(bm.err), 32'd0);
    chk("bad_clr_count", 32'(bm.digit_count), 32'd0);

    // Back-to-back frames with out_ready tied high: one stall cycle between frames
    q_m.push_back('{16'h1234, 4, 0});
    q_m.push_back('{16'h5678, 4, 0});
    bm.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      send(1'b0, 4'(i), 1'b0, st);
      if (i == 5) chk("b2b_gap", 32'(st), 32'd1);
      else if (i > 1) chk($sformatf("b2b_nogap%0d", i), 32'(st), 32'd0);
    end
    @(posedge clk); #1;
    bm.out_ready = 1'b0;

    // clear beats a simultaneous accept
    send(1'b0, 4'd1, 1'b0, st);
    send(1'b0, 4'd2, 1'b0, st);
    bm.in_valid = 1'b1; bm.bcd_digit = 4'd3; clear = 1'b1;
    @(posedge clk); #1;
    bm.in_valid = 1'b0; clear = 1'b0;
    chk("clr_dec", 32'(bm.dec), 32'd0);
    chk("clr_count", 32'(bm.digit_count), 32'd0);
    chk("clr_in_ready", 32'(bm.in_ready), 32'd1);
    q_m.push_back('{16'h4321, 4, 0});
    send(1'b0, 4'd4, 1'b0, st);
    send(1'b0, 4'd3, 1'b0, st);
    send(1'b0, 4'd2, 1'b0, st);
    send(1'b0, 4'd1, 1'b0, st);
    pulse_out_ready(1'b0);

    // Async reset mid-cycle while holding an LSD-first full frame
    q_l.push_back('{16'h4321, 4, 0});
    send(1'b1, 4'd1, 1'b0, st);
    send(1'b1, 4'd2, 1'b0, st);
    send(1'b1, 4'd3, 1'b0, st);
    send(1'b1, 4'd4, 1'b0, st);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_out_valid", 32'(bl.out_valid), 32'd0);
    chk("arst_dec", 32'(bl.dec), 32'd0);
    chk("arst_in_ready", 32'(bl.in_ready), 32'd1);
    #3 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("msd_queue_drained", 32'(q_m.size()), 32'd0);
    chk("lsd_queue_drained", 32'(q_l.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/bcd_frame_collector.md
# bcd_frame_collector

Parametrised BCD digit collector: accepts one 4-bit BCD digit per cycle over a valid/ready handshake and assembles them into a frame of up to NUM_DIGITS digits. Supports early frame termination, selectable digit order, invalid-digit substitution with error reporting, and a held output frame with its own valid/ready handshake. Sits between a serial digit source (keypad/UART decoder) and downstream decimal arithmetic or display logic.

## Interface
- NUM_DIGITS, 300, maximum digits per frame (≥2)
- MSD_FIRST, 1, 1: first digit received is most significant; 0: first digit received is least significant
- CNT_W, $clog2(NUM_DIGITS+1), width of the count outputs (derived, not overridden)

- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- clear  input  1  synchronous abort: discard partial/held frame, return to COLLECT
- in_valid  input  1  bcd_digit is valid
- in_ready  output  1  block accepts a digit this cycle
- bcd_digit  input  4  BCD digit
- in_last  input  1  accepted digit is the final digit of the frame
- dec  output  4*NUM_DIGITS  assembled frame, digit slot k at [4k+3:4k], slot 0 least significant
- out_valid  output  1  frame complete and held on dec
- out_ready  input  1  consumer accepts the frame
- digit_count  output  CNT_W  digits accepted in current/held frame
- bad_count  output  CNT_W  digits >9 in current/held frame
- err  output  1  bad_count ≠ 0

## Operation
- States: COLLECT, HOLD. Reset state COLLECT.
- Reset values: dec=0, digit_count=0, bad_count=0, err=0, out_valid=0, in_ready=1.
- in_ready = (state==COLLECT); out_valid = (state==HOLD). Both pure state decodes.
- Accept = in_valid && in_ready. On accept: stored digit = bcd_digit if ≤9, else 4'd0 and bad_count+1; digit_count+1.
- MSD_FIRST=1: dec shifts left 4 bits, stored digit enters slot 0. Short frame is right-justified with leading zeros.
- MSD_FIRST=0: stored digit written to slot digit_count (pre-increment); unwritten slots stay 0.
- COLLECT→HOLD on accept when in_last=1 or digit_count==NUM_DIGITS-1 (frame full). Full frame ends regardless of in_last.
- HOLD: dec, digit_count, bad_count, err frozen; in_valid ignored. On out_ready: dec, counts, err cleared to 0, →COLLECT.
- clear (any state): same effect as out_ready in HOLD; wins over a simultaneous accept (digit discarded) and over out_ready.
- reset mid-frame: immediate return to reset values; partial frame lost.
- err is combinational from bad_count (no separate flop).

## Timing
- One digit per cycle sustained in COLLECT.
- Final digit accepted at edge N → out_valid=1 and frame visible on dec from edge N onward.
- out_ready sampled high at edge M in HOLD → in_ready=1 after edge M; earliest next accept at edge M+1. Minimum one non-accepting cycle between frames.
- out_ready in COLLECT has no effect.
- No combinational path from in_valid/out_ready to any output.

## Structure
- Shared package bcd_pkg: BCD_MAX = 4'd9, state enum {COLLECT, HOLD}, function bcd_sanitize(digit) returning {bad, stored_digit}.
- One natural sub-module: bcd_digit_check (combinational sanitize + bad flag), reusable by other BCD blocks.
- Storage is a flat 4*NUM_DIGITS register; MSD_FIRST selected by generate.

## Test plan
- NUM_DIGITS=4, MSD_FIRST=1: send 1,2,3,4 back-to-back → out_valid after 4th edge, dec=16'h1234, digit_count=4, err=0, in_ready=0.
- NUM_DIGITS=4, MSD_FIRST=0: send 1,2 with in_last on 2 → dec=16'h0021, digit_count=2; hold out_ready=0 for 5 cycles with in_valid=1 → dec unchanged, no digit accepted.
- Invalid digits: send 7, 4'hC, 4'hF, 3 → dec=16'h7003, bad_count=2, err=1; out_ready → all counts 0, err=0 next cycle.
- Back-to-back frames with out_ready tied high: two frames 1,2,3,4 and 5,6,7,8 → exactly one cycle in_ready=0 between them, second dec=16'h5678.
- clear asserted with in_valid on 3rd digit of a frame → digit discarded, dec=0, digit_count=0, state COLLECT; following 4-digit frame correct.
- Async reset asserted mid-cycle while in HOLD → out_valid=0, dec=0, in_ready=1 immediately, without a clock edge.
